// File: rtl/bf16_mac_pkg.sv
// Shared definitions for the bfloat16 MAC initiator.
// Contents: bf16 word width and zero constant, MAC cntl encodings
// (accumulate/load), and the sequencer state type.
package bf16_mac_pkg;

    localparam int                BF16_W    = 16;
    localparam logic [BF16_W-1:0] BF16_ZERO = 16'h0000;

    // MAC cntl: accumulate adds a*b to out, load replaces out with a*b.
    localparam logic CNTL_ACC  = 1'b0;
    localparam logic CNTL_LOAD = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/bf16_mac_sequencer.sv
// bf16_mac_sequencer
// Initiator-side controller for an external bfloat16 MAC. Takes VEC_LEN
// operand pairs over valid/ready, issues one pair per cycle to the MAC
// (first pair as a load, the rest as accumulates), waits MAC_LAT edges for
// the accumulator to settle, then holds the dot product on a valid/ready
// result port.
//
// Parameters:
//   VEC_LEN   operand pairs per dot product (1..255)
//   MAC_LAT   edges from the MAC sampling a/b until out reflects it (1..7)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand pair handshake, in_a/in_b bf16 operands
//   flush                 synchronous abort of partial vector or held result
//   mac_a/mac_b/mac_cntl  registered operands and load/accumulate to MAC
//   mac_out               MAC accumulator value
//   res_valid/res_ready   result handshake, res_data captured dot product
//   busy                  high in every state except IDLE
module bf16_mac_sequencer
    import bf16_mac_pkg::*;
#(
    parameter int VEC_LEN = 4,
    parameter int MAC_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BF16_W-1:0] in_a,
    input  logic [BF16_W-1:0] in_b,
    input  logic              flush,
    output logic [BF16_W-1:0] mac_a,
    output logic [BF16_W-1:0] mac_b,
    output logic              mac_cntl,
    input  logic [BF16_W-1:0] mac_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [BF16_W-1:0] res_data,
    output logic              busy
);

    localparam logic [7:0] VEC_LEN_C = 8'(VEC_LEN);
    localparam logic [2:0] MAC_LAT_C = 3'(MAC_LAT);

    seq_state_t state;
    logic [7:0] pair_cnt;
    logic [2:0] drain_cnt;
    logic       accept;
    logic       last_pair;

    always_comb in_ready = (state == IDLE) || (state == ISSUE);
    always_comb busy     = (state != IDLE);

    // flush wins over the input handshake even though in_ready stays high.
    always_comb accept = in_valid && in_ready && !flush;

    // True when the pair being accepted this cycle completes the vector.
    always_comb begin
        last_pair = 1'b0;
        if (state == IDLE)
            last_pair = (VEC_LEN_C == 8'd1);
        else if (state == ISSUE)
            last_pair = ((pair_cnt + 8'd1) == VEC_LEN_C);
    end

    // Operand issue stage: every cycle without an accepted pair sends a
    // zero bubble with accumulate, so the MAC adds +0 and holds its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_a    <= BF16_ZERO;
            mac_b    <= BF16_ZERO;
            mac_cntl <= CNTL_ACC;
        end else if (accept) begin
            mac_a    <= in_a;
            mac_b    <= in_b;
            mac_cntl <= (state == IDLE) ? CNTL_LOAD : CNTL_ACC;
        end else begin
            mac_a    <= BF16_ZERO;
            mac_b    <= BF16_ZERO;
            mac_cntl <= CNTL_ACC;
        end
    end

    // Sequencing and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pair_cnt  <= 8'd0;
            drain_cnt <= 3'd0;
            res_valid <= 1'b0;
            res_data  <= BF16_ZERO;
        end else if (flush) begin
            // Accumulator contents are left stale; the next vector loads.
            state     <= IDLE;
            pair_cnt  <= 8'd0;
            drain_cnt <= 3'd0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pair_cnt <= 8'd1;
                        if (last_pair) begin
                            state     <= DRAIN;
                            drain_cnt <= MAC_LAT_C;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        pair_cnt <= pair_cnt + 8'd1;
                        if (last_pair) begin
                            state     <= DRAIN;
                            drain_cnt <= MAC_LAT_C;
                        end
                    end
                end
                DRAIN: begin
                    // Count reaches zero MAC_LAT edges after the last accept,
                    // so the capture lands MAC_LAT+1 edges after it.
                    if (drain_cnt == 3'd0) begin
                        res_data  <= mac_out;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        pair_cnt  <= 8'd0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bf16_mac_sequencer.sv
// Testbench for bf16_mac_sequencer: two instances (VEC_LEN=4/MAC_LAT=1 and
// VEC_LEN=1/MAC_LAT=3), each paired with a behavioural bf16 MAC model.
module tb_bf16_mac_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Instance 0: VEC_LEN=4, MAC_LAT=1
    logic        d0_in_valid, d0_in_ready, d0_flush, d0_mac_cntl;
    logic        d0_res_valid, d0_res_ready, d0_busy;
    logic [15:0] d0_in_a, d0_in_b, d0_mac_a, d0_mac_b, d0_mac_out, d0_res_data;

    // Instance 1: VEC_LEN=1, MAC_LAT=3
    logic        d1_in_valid, d1_in_ready, d1_flush, d1_mac_cntl;
    logic        d1_res_valid, d1_res_ready, d1_busy;
    logic [15:0] d1_in_a, d1_in_b, d1_mac_a, d1_mac_b, d1_mac_out, d1_res_data;

    bf16_mac_sequencer #(.VEC_LEN(4), .MAC_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d0_in_valid), .in_ready(d0_in_ready),
        .in_a(d0_in_a), .in_b(d0_in_b), .flush(d0_flush),
        .mac_a(d0_mac_a), .mac_b(d0_mac_b), .mac_cntl(d0_mac_cntl),
        .mac_out(d0_mac_out),
        .res_valid(d0_res_valid), .res_ready(d0_res_ready),
        .res_data(d0_res_data), .busy(d0_busy)
    );

    bf16_mac_sequencer #(.VEC_LEN(1), .MAC_LAT(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .in_a(d1_in_a), .in_b(d1_in_b), .flush(d1_flush),
        .mac_a(d1_mac_a), .mac_b(d1_mac_b), .mac_cntl(d1_mac_cntl),
        .mac_out(d1_mac_out),
        .res_valid(d1_res_valid), .res_ready(d1_res_ready),
        .res_data(d1_res_data), .busy(d1_busy)
    );

    // ---------------- bf16 MAC models ----------------
    function automatic real bf2real(input logic [15:0] x);
        real m;
        int  e;
        e = int'(x[14:7]);
        if (e == 0) return 0.0;
        m = 1.0 + real'(int'(x[6:0])) / 128.0;
        while (e > 127) begin m = m * 2.0; e--; end
        while (e < 127) begin m = m / 2.0; e++; end
        return x[15] ? -m : m;
    endfunction

    function automatic logic [15:0] real2bf(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 16'h0000;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        return {d[63], e[7:0], d[51:45]};
    endfunction

    real acc0 = 0.0;
    always @(posedge clk) begin
        if (d0_mac_cntl) acc0 <= bf2real(d0_mac_a) * bf2real(d0_mac_b);
        else             acc0 <= acc0 + bf2real(d0_mac_a) * bf2real(d0_mac_b);
    end
    always_comb d0_mac_out = real2bf(acc0);

    // Latency 3: accumulate on the sampling edge, then two output delay stages.
    real         acc1 = 0.0;
    logic [15:0] m1_q1 = 16'h0, m1_q2 = 16'h0;
    always @(posedge clk) begin
        if (d1_mac_cntl) acc1 <= bf2real(d1_mac_a) * bf2real(d1_mac_b);
        else             acc1 <= acc1 + bf2real(d1_mac_a) * bf2real(d1_mac_b);
        m1_q1 <= real2bf(acc1);
        m1_q2 <= m1_q1;
    end
    always_comb d1_mac_out = m1_q2;

    // ---------------- scoreboard and stimulus helpers ----------------
    logic [15:0] exp_q[$];
    logic [15:0] va[4];
    logic [15:0] vb[4];
    logic [3:0]  obs_cntl;
    logic        gap_nz;
    int          miss;
    int          last_acc;

    function automatic logic [15:0] pop_exp();
        if (exp_q.size() > 0) return exp_q.pop_front();
        return 16'hxxxx;
    endfunction

    task automatic set_test1_vec();
        va = '{16'h3F80, 16'h3F00, 16'h4000, 16'hBF80};
        vb = '{16'h3F80, 16'h3F00, 16'h4040, 16'h3F80};
    endtask

    // Called at a negedge; drives n pairs on instance 0, optionally
    // inserting gap_len idle cycles before pair index gap_at.
    task automatic send_vec(input int n, input int gap_at, input int gap_len);
        miss = 0; gap_nz = 1'b0; obs_cntl = 4'b0;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    d0_in_valid = 1'b0;
                    @(negedge clk);
                    if (d0_mac_a != 16'h0 || d0_mac_b != 16'h0 || d0_mac_cntl != 1'b0)
                        gap_nz = 1'b1;
                end
            end
            if (!d0_in_ready) miss++;
            d0_in_valid = 1'b1; d0_in_a = va[i]; d0_in_b = vb[i];
            @(negedge clk);
            obs_cntl[i] = d0_mac_cntl;
            last_acc = cyc;
        end
        d0_in_valid = 1'b0;
    endtask

    task automatic wait_res0(output int at);
        at = -1;
        for (int k = 0; k < 40; k++) begin
            if (d0_res_valid) begin at = cyc; break; end
            @(negedge clk);
        end
    endtask

    task automatic release_res0();
        d0_res_ready = 1'b1;
        @(negedge clk);
        d0_res_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total += 7;
        if (d0_mac_a !== 16'h0)    begin bad++; $display("FAIL reset_mac_a: got %h want 0000", d0_mac_a); end
        if (d0_mac_b !== 16'h0)    begin bad++; $display("FAIL reset_mac_b: got %h want 0000", d0_mac_b); end
        if (d0_mac_cntl !== 1'b0)  begin bad++; $display("FAIL reset_mac_cntl: got %b want 0", d0_mac_cntl); end
        if (d0_res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %b want 0", d0_res_valid); end
        if (d0_res_data !== 16'h0) begin bad++; $display("FAIL reset_res_data: got %h want 0000", d0_res_data); end
        if (d0_busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", d0_busy); end
        if (d0_in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready: got %b want 1", d0_in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_full(input string nm, input int gap_at, input int gap_len);
        int at;
        logic [15:0] ev;
        send_vec(4, gap_at, gap_len);
        total += 2;
        if (miss != 0) begin bad++; $display("FAIL %s_in_ready: %0d pairs offered while not ready, want 0", nm, miss); end
        if (obs_cntl !== 4'b0001) begin bad++; $display("FAIL %s_cntl: got %b want 0001", nm, obs_cntl); end
        wait_res0(at);
        ev = pop_exp();
        total += 2;
        if (at - last_acc != 2) begin bad++; $display("FAIL %s_latency: got %0d edges want 2", nm, at - last_acc); end
        if (d0_res_data !== ev) begin bad++; $display("FAIL %s_data: got %h want %h", nm, d0_res_data, ev); end
        release_res0();
        total += 2;
        if (d0_res_valid !== 1'b0) begin bad++; $display("FAIL %s_release_valid: got %b want 0", nm, d0_res_valid); end
        if (d0_in_ready !== 1'b1)  begin bad++; $display("FAIL %s_release_ready: got %b want 1", nm, d0_in_ready); end
    endtask

    task automatic test_basic();
        set_test1_vec();
        exp_q.push_back(16'h40C8);
        run_full("basic", -1, 0);
    endtask

    task automatic test_load_clears();
        va = '{16'h3F00, 16'h3F00, 16'h3F00, 16'h3F00};
        vb = '{16'h3F00, 16'h3F00, 16'h3F00, 16'h3F00};
        exp_q.push_back(16'h3F80);
        run_full("load", -1, 0);
    endtask

    task automatic test_bubbles();
        set_test1_vec();
        exp_q.push_back(16'h40C8);
        run_full("bubble", 2, 3);
        total++;
        if (gap_nz !== 1'b0) begin bad++; $display("FAIL bubble_gap_zero: got %b want 0", gap_nz); end
    endtask

    task automatic test_backpressure();
        int at;
        logic [15:0] ev;
        logic [15:0] first;
        set_test1_vec();
        exp_q.push_back(16'h40C8);
        send_vec(4, -1, 0);
        wait_res0(at);
        ev = pop_exp();
        first = d0_res_data;
        total += 2;
        if (at < 0)          begin bad++; $display("FAIL bp_res_valid: got timeout want result"); end
        if (first !== ev)    begin bad++; $display("FAIL bp_data: got %h want %h", first, ev); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total += 4;
            if (d0_res_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, d0_res_valid); end
            if (d0_res_data !== ev)    begin bad++; $display("FAIL bp_hold_data[%0d]: got %h want %h", k, d0_res_data, ev); end
            if (d0_in_ready !== 1'b0)  begin bad++; $display("FAIL bp_hold_in_ready[%0d]: got %b want 0", k, d0_in_ready); end
            if (d0_busy !== 1'b1)      begin bad++; $display("FAIL bp_hold_busy[%0d]: got %b want 1", k, d0_busy); end
        end
        release_res0();
        total += 2;
        if (d0_res_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", d0_res_valid); end
        if (d0_in_ready !== 1'b1)  begin bad++; $display("FAIL bp_release_ready: got %b want 1", d0_in_ready); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        set_test1_vec();
        send_vec(2, -1, 0);
        #2 rst_n = 1'b0;
        #1;
        total += 7;
        if (d0_mac_a !== 16'h0)    begin bad++; $display("FAIL rstmid_mac_a: got %h want 0000", d0_mac_a); end
        if (d0_mac_b !== 16'h0)    begin bad++; $display("FAIL rstmid_mac_b: got %h want 0000", d0_mac_b); end
        if (d0_mac_cntl !== 1'b0)  begin bad++; $display("FAIL rstmid_mac_cntl: got %b want 0", d0_mac_cntl); end
        if (d0_res_valid !== 1'b0) begin bad++; $display("FAIL rstmid_res_valid: got %b want 0", d0_res_valid); end
        if (d0_res_data !== 16'h0) begin bad++; $display("FAIL rstmid_res_data: got %h want 0000", d0_res_data); end
        if (d0_busy !== 1'b0)      begin bad++; $display("FAIL rstmid_busy: got %b want 0", d0_busy); end
        if (d0_in_ready !== 1'b1)  begin bad++; $display("FAIL rstmid_in_ready: got %b want 1", d0_in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (d0_res_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_result: got res_valid=%b want 0", seen); end
        exp_q.push_back(16'h40C8);
        run_full("rstmid_after", -1, 0);
    endtask

    task automatic test_flush_mid();
        logic seen;
        set_test1_vec();
        send_vec(2, -1, 0);
        d0_flush = 1'b1; d0_in_valid = 1'b1; d0_in_a = 16'h4000; d0_in_b = 16'h4040;
        @(negedge clk);
        d0_flush = 1'b0; d0_in_valid = 1'b0;
        total += 3;
        if (d0_busy !== 1'b0)     begin bad++; $display("FAIL flush_busy: got %b want 0", d0_busy); end
        if (d0_mac_a !== 16'h0)   begin bad++; $display("FAIL flush_suppress_a: got %h want 0000", d0_mac_a); end
        if (d0_mac_cntl !== 1'b0) begin bad++; $display("FAIL flush_cntl: got %b want 0", d0_mac_cntl); end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (d0_res_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_result: got res_valid=%b want 0", seen); end
        exp_q.push_back(16'h40C8);
        run_full("flush_after", -1, 0);
    endtask

    task automatic test_vec1_lat3();
        int acc;
        int at;
        logic [15:0] ev;
        total++;
        if (d1_in_ready !== 1'b1) begin bad++; $display("FAIL v1_in_ready: got %b want 1", d1_in_ready); end
        exp_q.push_back(16'h40C0);
        d1_in_valid = 1'b1; d1_in_a = 16'h4000; d1_in_b = 16'h4040;
        @(negedge clk);
        d1_in_valid = 1'b0;
        acc = cyc;
        total += 3;
        if (d1_mac_cntl !== 1'b1) begin bad++; $display("FAIL v1_cntl: got %b want 1", d1_mac_cntl); end
        if (d1_in_ready !== 1'b0) begin bad++; $display("FAIL v1_drain_in_ready: got %b want 0", d1_in_ready); end
        if (d1_busy !== 1'b1)     begin bad++; $display("FAIL v1_busy: got %b want 1", d1_busy); end
        at = -1;
        for (int k = 0; k < 40; k++) begin
            if (d1_res_valid) begin at = cyc; break; end
            @(negedge clk);
        end
        ev = pop_exp();
        total += 2;
        if (at - acc != 4)      begin bad++; $display("FAIL v1_latency: got %0d edges want 4", at - acc); end
        if (d1_res_data !== ev) begin bad++; $display("FAIL v1_data: got %h want %h", d1_res_data, ev); end
        d1_res_ready = 1'b1;
        @(negedge clk);
        d1_res_ready = 1'b0;
        total++;
        if (d1_res_valid !== 1'b0) begin bad++; $display("FAIL v1_release: got %b want 0", d1_res_valid); end
    endtask

    initial begin
        rst_n = 1'b0;
        d0_in_valid = 1'b0; d0_in_a = 16'h0; d0_in_b = 16'h0; d0_flush = 1'b0; d0_res_ready = 1'b0;
        d1_in_valid = 1'b0; d1_in_a = 16'h0; d1_in_b = 16'h0; d1_flush = 1'b0; d1_res_ready = 1'b0;
        test_reset();
        test_basic();
        test_load_clears();
        test_bubbles();
        test_backpressure();
        test_reset_mid();
        test_flush_mid();
        test_vec1_lat3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bf16_mac_sequencer.md
Name: bf16_mac_sequencer

Overview:
- Initiator-side controller for the bfloat16 MAC block (ports a, b, cntl, out).
- Accepts a stream of bf16 operand pairs over a valid/ready interface and drives the MAC one pair per cycle.
- After VEC_LEN pairs, waits out the MAC latency, captures the accumulated dot product and presents it on a valid/ready result port.
- Sits between the operand-fetch logic and the MAC; the MAC is instantiated alongside it, not inside it.

Parameters:
- VEC_LEN, 4: operand pairs per dot product; legal range 1..255.
- MAC_LAT, 1: clock edges from the MAC sampling a/b until out reflects that product; legal range 1..7.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_a  in  16  bf16 operand A.
- in_b  in  16  bf16 operand B.
- flush  in  1  synchronous abort; drops any partial vector or held result.
- mac_a  out  16  registered operand A to MAC.
- mac_b  out  16  registered operand B to MAC.
- mac_cntl  out  1  0 = accumulate (out += a*b); 1 = load (out = a*b).
- mac_out  in  16  MAC accumulator value.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_data  out  16  captured bf16 dot product.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, asynchronous: state=IDLE; mac_a=0, mac_b=0, mac_cntl=0, res_valid=0, res_data=0, all counters 0.
- in_ready and busy are combinational from state.
- Handshakes: transfer when valid&&ready on a rising edge. in_ready=1 only in IDLE and ISSUE.
- Bubble: any cycle without an accepted pair registers mac_a=0, mac_b=0, mac_cntl=0. The accumulator then adds +0 and holds its value.
- IDLE: on accept, register mac_a=in_a, mac_b=in_b, mac_cntl=1 (load clears previous vector), pair_cnt=1.
  - Next state is ISSUE, or DRAIN if VEC_LEN==1.
- ISSUE: on accept, register the pair with mac_cntl=0 and increment pair_cnt.
  - When the accept makes pair_cnt==VEC_LEN, go to DRAIN with drain_cnt=MAC_LAT.
  - Gaps in in_valid insert bubbles; pair_cnt holds.
- DRAIN: in_ready=0; bubbles issued; drain_cnt decrements each cycle.
  - At drain_cnt==0, capture res_data=mac_out, set res_valid=1 and go to HOLD.
  - The capture edge is exactly MAC_LAT+1 edges after the last pair's accept edge.
- HOLD: res_valid=1; res_data stable; in_ready=0.
  - On res_ready, clear res_valid on that edge and go to IDLE.
  - The next vector can be accepted in the cycle after that edge.
- Minimum vector turnaround is VEC_LEN + MAC_LAT + 2 cycles with no backpressure.
- flush: highest priority over every handshake in the same cycle.
  - Forces state=IDLE, res_valid=0, a bubble on the MAC, pair_cnt=0.
  - Accumulator contents are don't-care, because the next vector starts with a load.
- Simultaneous in_valid and flush in IDLE or ISSUE: the pair is not accepted. in_ready remains 1 by state, but flush suppresses the transfer.
- Reset mid-operation: the same as the reset values above. The partial vector is lost and no result is emitted for it.
- The sequencer does no arithmetic on data. It never inspects bf16 fields; NaN, Inf and denormals pass through the MAC untouched.

Decomposition:
- Shared package bf16_mac_pkg holds:
  - BF16_W=16 and BF16_ZERO=16'h0000;
  - constants CNTL_ACC=1'b0 and CNTL_LOAD=1'b1;
  - typedef enum seq_state_t {IDLE, ISSUE, DRAIN, HOLD}.
- Single module; no sub-module is warranted. Counters are sized from the parameter ranges (8-bit pair_cnt, 3-bit drain_cnt).

Test Plan:
- Basic dot product, VEC_LEN=4, MAC_LAT=1, back-to-back pairs: (3F80,3F80), (3F00,3F00), (4000,4040), (BF80,3F80).
  - Required: mac_cntl=1 only on the first pair.
  - Required: res_valid rises 2 edges after the 4th accept, with res_data=16'h40C8 (6.25).
- Load clears previous vector: immediately after test 1, send 4×(3F00,3F00).
  - Required: res_data=16'h3F80 (1.0), with no carryover of 6.25.
- Input bubbles: the test 1 vector with in_valid low for 3 cycles between pairs 2 and 3.
  - Required: mac_a/mac_b=0 and mac_cntl=0 during gaps; res_data=16'h40C8.
- Result backpressure: hold res_ready=0 for 5 cycles after res_valid.
  - Required: res_valid stays 1, res_data stays stable, in_ready=0, busy=1.
  - Required: after res_ready=1, in the next cycle res_valid=0 and in_ready=1.
- Reset and flush mid-ISSUE: after 2 pairs, pulse rst_n low (async, mid-cycle).
  - Required: all outputs 0 and no result emitted.
  - Repeat the scenario with flush=1 for one cycle instead of reset: state returns to IDLE.
  - After either, the test 1 vector again yields 16'h40C8.
- VEC_LEN=1, MAC_LAT=3: a single pair (4000,4040).
  - Required: DRAIN entered directly from IDLE; res_data=16'h40C0 (6.0) exactly 4 edges after accept.
